// File: rtl/agc_pkg.sv
// Shared classification type and width-derived thresholds for the multi-channel AGC.
package agc_pkg;

  typedef enum logic [1:0] {CLS_LOW, CLS_MID, CLS_CLIP} agc_cls_e;

  // Saturation rails of a signed w-bit output.
  function automatic longint sat_hi(int unsigned w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_lo(int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // Open interval bounds for a "low" sample: (low_lo, low_hi).
  function automatic longint low_hi(int unsigned w);
    return (longint'(1) <<< (w - 2)) - 1;
  endfunction

  function automatic longint low_lo(int unsigned w);
    return -(longint'(1) <<< (w - 2));
  endfunction

endpackage

// File: rtl/agc_sat_shift.sv
// Combinational arithmetic shift, saturation to OUT_WIDTH and clip/low/mid classification.
module agc_sat_shift
  import agc_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = 41,
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned SHIFT_WIDTH = 5
) (
  input  logic [IN_WIDTH-1:0]    din,
  input  logic [SHIFT_WIDTH-1:0] shift,
  output logic [OUT_WIDTH-1:0]   dout,
  output agc_cls_e               cls
);

  localparam logic signed [IN_WIDTH-1:0] SatHi = IN_WIDTH'(sat_hi(OUT_WIDTH));
  localparam logic signed [IN_WIDTH-1:0] SatLo = IN_WIDTH'(sat_lo(OUT_WIDTH));
  localparam logic signed [IN_WIDTH-1:0] LowHi = IN_WIDTH'(low_hi(OUT_WIDTH));
  localparam logic signed [IN_WIDTH-1:0] LowLo = IN_WIDTH'(low_lo(OUT_WIDTH));

  logic signed [IN_WIDTH-1:0] y;
  logic                       over;
  logic                       under;

  always_comb begin
    y     = $signed(din) >>> shift;
    over  = y > SatHi;
    under = y < SatLo;
    cls   = CLS_MID;
    if (over || under) begin
      cls = CLS_CLIP;
    end else if (y > LowLo && y < LowHi) begin
      cls = CLS_LOW;
    end
    if (over) begin
      dout = SatHi[OUT_WIDTH-1:0];
    end else if (under) begin
      dout = SatLo[OUT_WIDTH-1:0];
    end else begin
      dout = y[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/multi_chan_agc.sv
// Per-channel AGC for a TDM AXI-Stream: shift, saturate, adapt shift from clip/low counts.
// Define MULTI_CHAN_AGC_STATUS_EN to add shift_status/clip_sticky outputs and clip_clr input.
module multi_chan_agc
  import agc_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = 41,
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned NUM_CHANS   = 13,
  parameter int unsigned CHAN_WIDTH  = 4,
  parameter int unsigned SHIFT_WIDTH = 5,
  parameter int unsigned MAX_SHIFT   = IN_WIDTH - OUT_WIDTH,
  parameter int unsigned INIT_SHIFT  = 0,
  parameter int unsigned HIGH_LIMIT  = 122800,
  parameter int unsigned LOW_LIMIT   = 614000000,
  parameter int unsigned WINDOW      = 122800000
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [IN_WIDTH-1:0]    s_axis_tdata,
  input  logic [CHAN_WIDTH-1:0]  s_axis_tuser,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [OUT_WIDTH-1:0]   m_axis_tdata,
  output logic [CHAN_WIDTH-1:0]  m_axis_tuser,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  input  logic                   cfg_freeze,
  input  logic                   cfg_shift_wr,
  input  logic [CHAN_WIDTH-1:0]  cfg_shift_chan,
  input  logic [SHIFT_WIDTH-1:0] cfg_shift_val
`ifdef MULTI_CHAN_AGC_STATUS_EN
  ,
  input  logic                             clip_clr,
  output logic [NUM_CHANS*SHIFT_WIDTH-1:0] shift_status,
  output logic [NUM_CHANS-1:0]             clip_sticky
`endif
);

  localparam int unsigned ClipW = $clog2(HIGH_LIMIT + 1);
  localparam int unsigned LowW  = $clog2(LOW_LIMIT + 1);
  localparam int unsigned TmrW  = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  localparam logic [SHIFT_WIDTH-1:0] MaxShift  = SHIFT_WIDTH'(MAX_SHIFT);
  localparam logic [SHIFT_WIDTH-1:0] InitShift = SHIFT_WIDTH'(INIT_SHIFT);
  localparam logic [ClipW-1:0]       HighLim   = ClipW'(HIGH_LIMIT);
  localparam logic [LowW-1:0]        LowLim    = LowW'(LOW_LIMIT);
  localparam logic [TmrW-1:0]        TmrLast   = TmrW'(WINDOW - 1);

  logic [SHIFT_WIDTH-1:0] shift_q [NUM_CHANS];
  logic [SHIFT_WIDTH-1:0] shift_d [NUM_CHANS];
  logic [ClipW-1:0]       clip_q  [NUM_CHANS];
  logic [ClipW-1:0]       clip_d  [NUM_CHANS];
  logic [LowW-1:0]        low_q   [NUM_CHANS];
  logic [LowW-1:0]        low_d   [NUM_CHANS];
  logic [TmrW-1:0]        tmr_q;

  logic                   accept;
  logic                   wrap;
  logic                   in_range;
  logic [SHIFT_WIDTH-1:0] cur_shift;
  logic [SHIFT_WIDTH-1:0] beat_shift;
  logic [OUT_WIDTH-1:0]   sat_data;
  agc_cls_e               cls;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign wrap          = (tmr_q == TmrLast);
  assign in_range      = 32'(s_axis_tuser) < NUM_CHANS;
  // Out-of-range channels pass through unshifted but still saturated.
  assign beat_shift    = in_range ? cur_shift : '0;

  always_comb begin
    cur_shift = '0;
    for (int c = 0; c < NUM_CHANS; c++) begin
      if (s_axis_tuser == CHAN_WIDTH'(c)) cur_shift = shift_q[c];
    end
  end

  agc_sat_shift #(
    .IN_WIDTH   (IN_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH)
  ) u_sat_shift (
    .din  (s_axis_tdata),
    .shift(beat_shift),
    .dout (sat_data),
    .cls  (cls)
  );

  always_comb begin
    shift_d = shift_q;
    clip_d  = clip_q;
    low_d   = low_q;
    for (int c = 0; c < NUM_CHANS; c++) begin
      if (wrap) clip_d[c] = '0;
      if (accept && !cfg_freeze && s_axis_tuser == CHAN_WIDTH'(c)) begin
        case (cls)
          CLS_CLIP: begin
            if (clip_d[c] != HighLim) clip_d[c] = clip_d[c] + 1'b1;
            low_d[c] = '0;
          end
          CLS_LOW: begin
            if (low_d[c] != LowLim) low_d[c] = low_d[c] + 1'b1;
          end
          default: low_d[c] = '0;
        endcase
        if (clip_d[c] == HighLim) begin
          if (shift_q[c] < MaxShift) shift_d[c] = shift_q[c] + 1'b1;
          clip_d[c] = '0;
          low_d[c]  = '0;
        end
        if (low_d[c] == LowLim) begin
          if (shift_q[c] != '0) shift_d[c] = shift_q[c] - 1'b1;
          low_d[c] = '0;
        end
      end
      // Manual write overrides any same-cycle adaptation, frozen or not.
      if (cfg_shift_wr && cfg_shift_chan == CHAN_WIDTH'(c)) begin
        shift_d[c] = (cfg_shift_val > MaxShift) ? MaxShift : cfg_shift_val;
        clip_d[c]  = '0;
        low_d[c]   = '0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int c = 0; c < NUM_CHANS; c++) begin
        shift_q[c] <= InitShift;
        clip_q[c]  <= '0;
        low_q[c]   <= '0;
      end
      tmr_q         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
    end else begin
      shift_q <= shift_d;
      clip_q  <= clip_d;
      low_q   <= low_d;
      tmr_q   <= wrap ? '0 : tmr_q + 1'b1;
      if (accept) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= sat_data;
        m_axis_tuser  <= s_axis_tuser;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

`ifdef MULTI_CHAN_AGC_STATUS_EN
  logic [NUM_CHANS-1:0] sticky_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sticky_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANS; c++) begin
        if (accept && cls == CLS_CLIP && s_axis_tuser == CHAN_WIDTH'(c)) begin
          sticky_q[c] <= 1'b1;
        end else if (clip_clr) begin
          sticky_q[c] <= 1'b0;
        end
      end
    end
  end

  assign clip_sticky = sticky_q;

  always_comb begin
    shift_status = '0;
    for (int c = 0; c < NUM_CHANS; c++) begin
      shift_status[c*SHIFT_WIDTH +: SHIFT_WIDTH] = shift_q[c];
    end
  end
`else
  // Status ports absent in this build.
`endif

endmodule

// File: tb/tb_multi_chan_agc.sv
// Self-checking bench for multi_chan_agc: directed scenarios plus randomized traffic vs a model.
module tb_multi_chan_agc;

  localparam int NCH    = 4;
  localparam int IN_W   = 24;
  localparam int OUT_W  = 16;
  localparam int CH_W   = 4;
  localparam int SH_W   = 5;
  localparam int MAXS   = IN_W - OUT_W;
  localparam int HIGH   = 4;
  localparam int LOW    = 8;
  localparam int WINDOW = 64;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b1;
  logic [IN_W-1:0]   s_axis_tdata = '0;
  logic [CH_W-1:0]   s_axis_tuser = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic [OUT_W-1:0]  m_axis_tdata;
  logic [CH_W-1:0]   m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              cfg_freeze = 1'b0;
  logic              cfg_shift_wr = 1'b0;
  logic [CH_W-1:0]   cfg_shift_chan = '0;
  logic [SH_W-1:0]   cfg_shift_val = '0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_shift [NCH];
  int          m_clip  [NCH];
  int          m_low   [NCH];
  int          m_tmr;
  bit          mv;
  logic [15:0] md;
  logic [3:0]  mu;

  multi_chan_agc #(
    .IN_WIDTH   (IN_W),
    .OUT_WIDTH  (OUT_W),
    .NUM_CHANS  (NCH),
    .CHAN_WIDTH (CH_W),
    .SHIFT_WIDTH(SH_W),
    .MAX_SHIFT  (MAXS),
    .INIT_SHIFT (0),
    .HIGH_LIMIT (HIGH),
    .LOW_LIMIT  (LOW),
    .WINDOW     (WINDOW)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .cfg_freeze    (cfg_freeze),
    .cfg_shift_wr  (cfg_shift_wr),
    .cfg_shift_chan(cfg_shift_chan),
    .cfg_shift_val (cfg_shift_val)
  );

  initial forever #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_shift[i] = 0;
      m_clip[i]  = 0;
      m_low[i]   = 0;
    end
    m_tmr = 0;
    mv    = 0;
    md    = '0;
    mu    = '0;
  endtask

  // One clock of the behaviour rules, using the inputs present before the edge.
  task automatic model_step();
    longint y, o;
    int ch, sh, v;
    bit acc, is_clip, is_low;
    acc = s_axis_tvalid && (!mv || m_axis_tready);
    if (m_tmr == WINDOW - 1) begin
      m_tmr = 0;
      for (int i = 0; i < NCH; i++) m_clip[i] = 0;
    end else begin
      m_tmr++;
    end
    if (acc) begin
      ch      = int'(s_axis_tuser);
      sh      = (ch < NCH) ? m_shift[ch] : 0;
      y       = longint'($signed(s_axis_tdata)) >>> sh;
      is_clip = (y > 32767) || (y < -32768);
      o       = (y > 32767) ? 32767 : (y < -32768) ? -32768 : y;
      is_low  = !is_clip && (y > -16384) && (y < 16383);
      if (ch < NCH && !cfg_freeze) begin
        if (is_clip) begin
          m_clip[ch]++;
          m_low[ch] = 0;
        end else if (is_low) begin
          m_low[ch]++;
        end else begin
          m_low[ch] = 0;
        end
        if (m_clip[ch] == HIGH) begin
          m_shift[ch] = (m_shift[ch] + 1 > MAXS) ? MAXS : m_shift[ch] + 1;
          m_clip[ch]  = 0;
          m_low[ch]   = 0;
        end
        if (m_low[ch] == LOW) begin
          m_shift[ch] = (m_shift[ch] > 0) ? m_shift[ch] - 1 : 0;
          m_low[ch]   = 0;
        end
      end
      mv = 1;
      md = o[15:0];
      mu = s_axis_tuser;
    end else if (m_axis_tready) begin
      mv = 0;
    end
    if (cfg_shift_wr && int'(cfg_shift_chan) < NCH) begin
      v = int'(cfg_shift_val);
      m_shift[cfg_shift_chan] = (v > MAXS) ? MAXS : v;
      m_clip[cfg_shift_chan]  = 0;
      m_low[cfg_shift_chan]   = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge aclk or negedge aresetn);
      if (!aresetn) model_reset();
      else model_step();
    end
  end

  // Continuous comparison of the DUT outputs against the model.
  initial forever begin
    @(posedge aclk);
    #1;
    if (aresetn) begin
      check_eq("tvalid", m_axis_tvalid, mv);
      check_eq("tready", s_axis_tready, !mv || m_axis_tready);
      if (mv) begin
        check_eq("tdata", m_axis_tdata, md);
        check_eq("tuser", m_axis_tuser, mu);
      end
    end
  end

  task automatic beat_chk(input string tag, input int ch, input logic [23:0] d,
                          input logic [15:0] exp);
    @(negedge aclk);
    s_axis_tvalid = 1'b1;
    s_axis_tuser  = 4'(ch);
    s_axis_tdata  = d;
    @(posedge aclk);
    #1;
    check_eq(tag, m_axis_tdata, exp);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_tmr(input int v);
    int n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (m_tmr != v && n < 200);
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_tmr: timer %0d never reached %0d", m_tmr, v);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int rk, rd;

  initial begin
    #2 aresetn = 1'b0;
    #1;
    check_eq("rst_tvalid", m_axis_tvalid, 0);
    check_eq("rst_tdata", m_axis_tdata, 0);
    check_eq("rst_tuser", m_axis_tuser, 0);
    check_eq("rst_tready", s_axis_tready, 1);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;

    // Passthrough
    beat_chk("pass_data", 1, 24'h001234, 16'h1234);
    check_eq("pass_user", m_axis_tuser, 1);

    // Saturation and shift increment on ch2
    wait_tmr(2);
    for (int i = 0; i < HIGH; i++) beat_chk("sat_clip", 2, 24'h100000, 16'h7FFF);
    beat_chk("sat_shift2", 2, 24'h00F000, 16'h7800);
    beat_chk("sat_ch0_keep", 0, 24'h000100, 16'h0100);
    beat_chk("sat_ch1_keep", 1, 24'h000100, 16'h0100);
    beat_chk("sat_ch3_keep", 3, 24'h000100, 16'h0100);

    // Decrement on ch0 with a restart by a mid beat
    @(negedge aclk);
    cfg_shift_wr = 1'b1; cfg_shift_chan = 4'd0; cfg_shift_val = 5'd3;
    @(posedge aclk);
    #1 cfg_shift_wr = 1'b0;
    for (int i = 0; i < 4; i++) beat_chk("dec_low", 0, 24'h000010, 16'h0002);
    beat_chk("dec_mid", 0, 24'h030000, 16'h6000);
    for (int i = 0; i < LOW - 1; i++) beat_chk("dec_low", 0, 24'h000010, 16'h0002);
    beat_chk("dec_restart", 0, 24'h030000, 16'h6000);
    for (int i = 0; i < LOW; i++) beat_chk("dec_low", 0, 24'h000010, 16'h0002);
    beat_chk("dec_shift2", 0, 24'h030000, 16'h7FFF);

    // Window wrap clears clip counts on ch3
    wait_tmr(2);
    for (int i = 0; i < 3; i++) beat_chk("win_clip_a", 3, 24'h00C000, 16'h7FFF);
    wait_tmr(2);
    for (int i = 0; i < 4; i++) beat_chk("win_clip_b", 3, 24'h00C000, 16'h7FFF);
    beat_chk("win_shift1", 3, 24'h00C000, 16'h6000);

    // Backpressure: output held, no acceptance
    @(negedge aclk);
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tuser = 4'd1; s_axis_tdata = 24'h000222;
    repeat (5) begin
      @(posedge aclk);
      #1;
      check_eq("bp_hold", m_axis_tdata, 16'h6000);
      check_eq("bp_tready", s_axis_tready, 0);
    end
    @(negedge aclk);
    m_axis_tready = 1'b1;
    @(posedge aclk);
    #1;
    check_eq("bp_release_data", m_axis_tdata, 16'h0222);
    check_eq("bp_release_user", m_axis_tuser, 1);
    s_axis_tvalid = 1'b0;

    // Manual write wins over the same-cycle auto increment on ch2
    wait_tmr(2);
    for (int i = 0; i < HIGH - 1; i++) beat_chk("wr_clip", 2, 24'h100000, 16'h7FFF);
    @(negedge aclk);
    s_axis_tvalid = 1'b1; s_axis_tuser = 4'd2; s_axis_tdata = 24'h100000;
    cfg_shift_wr = 1'b1; cfg_shift_chan = 4'd2; cfg_shift_val = 5'd31;
    @(posedge aclk);
    #1;
    check_eq("wr_clip4", m_axis_tdata, 16'h7FFF);
    s_axis_tvalid = 1'b0;
    cfg_shift_wr  = 1'b0;
    beat_chk("wr_shift_max", 2, 24'h7F0000, 16'h7F00);

    // Out-of-range channel: unshifted, saturated
    beat_chk("oor_sat", 5, 24'h800000, 16'h8000);
    beat_chk("oor_pass", 6, 24'hFFFF00, 16'hFF00);

    // Reset while an output beat is stalled
    @(negedge aclk);
    m_axis_tready = 1'b0;
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check_eq("rst_mid_tvalid", m_axis_tvalid, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    beat_chk("rst_shift0", 2, 24'h7F0000, 16'h7FFF);

    // Randomized traffic
    repeat (3000) begin
      @(negedge aclk);
      s_axis_tvalid  = ($urandom_range(0, 3) != 0);
      s_axis_tuser   = 4'($urandom_range(0, 5));
      rk             = int'($urandom_range(2, 23));
      rd             = int'($urandom & ((32'd1 << rk) - 1));
      if ($urandom_range(0, 1) == 1) rd = -rd;
      s_axis_tdata   = rd[23:0];
      m_axis_tready  = ($urandom_range(0, 3) != 0);
      cfg_freeze     = ($urandom_range(0, 15) == 0);
      cfg_shift_wr   = ($urandom_range(0, 31) == 0);
      cfg_shift_chan = 4'($urandom_range(0, 5));
      cfg_shift_val  = 5'($urandom_range(0, 31));
    end
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    cfg_shift_wr  = 1'b0;
    cfg_freeze    = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge aclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_chan_agc.md
Name: multi_chan_agc

Overview:
- Per-channel automatic gain stage for a TDM multi-channel sample stream; successor to the single-channel fixed-width FIR output shifter.
- Sits between the FIR decimator output and the packetiser/FIFO.
- Each accepted beat is arithmetic-right-shifted by its channel's own shift value, saturated to OUT_WIDTH and forwarded over AXI-Stream.
- Each channel's shift adapts independently from clip and low-level counters, with full backpressure support.

Parameters:
- IN_WIDTH, 41, signed input sample width.
- OUT_WIDTH, 16, signed output sample width.
- NUM_CHANS, 13, number of TDM channels.
- CHAN_WIDTH, 4, width of the channel index field (tuser).
- SHIFT_WIDTH, 5, width of each per-channel shift register.
- MAX_SHIFT, IN_WIDTH-OUT_WIDTH, upper bound on the shift value.
- INIT_SHIFT, 0, shift value loaded on reset.
- HIGH_LIMIT, 122800, number of clipped beats within one window that triggers a shift increment.
- LOW_LIMIT, 614000000, number of consecutive low beats that triggers a shift decrement.
- WINDOW, 122800000, clip-counting window length in aclk cycles.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  IN_WIDTH  signed sample.
- s_axis_tuser  in  CHAN_WIDTH  channel index.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  OUT_WIDTH  shifted, saturated sample.
- m_axis_tuser  out  CHAN_WIDTH  channel index, passed through.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- cfg_freeze  in  1  when high, hold all shifts and counters.
- cfg_shift_wr  in  1  one-cycle manual shift write strobe.
- cfg_shift_chan  in  CHAN_WIDTH  channel targeted by the manual write.
- cfg_shift_val  in  SHIFT_WIDTH  value for the manual write.

Behaviour:
- Reset (async assert, sync release):
  - shift[c] = INIT_SHIFT for every channel.
  - All clip counters, low counters and the window timer = 0.
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tuser = 0.
- Handshake:
  - s_axis_tready = !m_axis_tvalid || m_axis_tready.
  - A beat is accepted when s_axis_tvalid && s_axis_tready.
  - Accepted data appears on the output register the next cycle (latency 1).
  - Output holds stable while m_axis_tvalid && !m_axis_tready.
  - tvalid drops only after a completed transfer with no new beat accepted.
- Datapath for channel c:
  - y = s_axis_tdata >>> shift[c], computed at full IN_WIDTH.
  - Saturate: y > 2^(OUT_WIDTH-1)-1 or y < -2^(OUT_WIDTH-1) gives the corresponding rail; otherwise output the low OUT_WIDTH bits.
- Classification per accepted beat:
  - clip = saturated.
  - low = |y| strictly inside (-2^(OUT_WIDTH-2), 2^(OUT_WIDTH-2)-1).
  - mid = neither clip nor low.
- Counter updates, only when cfg_freeze = 0 and c < NUM_CHANS:
  - clip: clip_cnt[c]++ (saturating), low_cnt[c] = 0.
  - low: low_cnt[c]++.
  - mid: low_cnt[c] = 0.
- Gain adaptation:
  - If post-update clip_cnt[c] == HIGH_LIMIT: shift[c]++ (held at MAX_SHIFT), then clip_cnt[c] = 0 and low_cnt[c] = 0.
  - If post-update low_cnt[c] == LOW_LIMIT: shift[c]-- (held at 0), then low_cnt[c] = 0.
  - The new shift takes effect from the next accepted beat of that channel.
- Window timer:
  - Counts every aclk cycle, including under backpressure and freeze.
  - Wraps at WINDOW-1, clearing all clip counters on the wrap cycle.
  - If a clip beat is accepted on the wrap cycle, that channel's clip_cnt = 1.
- Manual write (cfg_shift_wr):
  - shift[cfg_shift_chan] = min(cfg_shift_val, MAX_SHIFT).
  - Clears both counters of that channel.
  - Wins over a same-cycle auto update on the same channel.
  - Acts even while frozen.
  - Ignored if cfg_shift_chan >= NUM_CHANS.
- Out-of-range tuser (>= NUM_CHANS): beat is forwarded with shift 0 and saturation; no state changes.
- Reset mid-transfer: output beat is dropped, tvalid forced to 0.

Optional Feature:
- Macro: MULTI_CHAN_AGC_STATUS_EN.
- Defined: adds output shift_status [NUM_CHANS*SHIFT_WIDTH] (packed shift[c], channel 0 in the LSBs) and clip_sticky [NUM_CHANS].
  - clip_sticky[c] sets on any clipped beat of channel c.
  - Cleared by input clip_clr (1-bit, one-cycle pulse); a set on the same cycle as clip_clr wins.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package agc_pkg:
  - Saturation limit constants derived from OUT_WIDTH.
  - Low-threshold constants.
  - Classification enum {CLS_LOW, CLS_MID, CLS_CLIP}.
- Sub-module agc_sat_shift: purely combinational shift, saturate and classify.
- The top level holds the state arrays, counters, timer and handshake.

Test Plan:
(Bench parameters: NUM_CHANS=4, IN_WIDTH=24, OUT_WIDTH=16, HIGH_LIMIT=4, LOW_LIMIT=8, WINDOW=64, INIT_SHIFT=0.)
- Passthrough: ch1 sample 0x001234 -> m_axis_tdata 0x1234, tuser 1, one cycle later.
- Saturation + increment: 4 beats of ch2 at 0x100000 within one window -> outputs 0x7FFF; shift[2] becomes 1; ch0/1/3 unchanged.
- Decrement: shift[0] manually set to 3, then 8 beats of ch0 at 0x000010 -> shift[0] = 2. A mid beat (0x6000 after shift) mid-sequence restarts the count.
- Window clear: 3 ch3 clips, window wraps, 3 more clips -> shift[3] stays 0. A 4th clip in the same window -> 1.
- Backpressure: m_axis_tready low for 5 cycles with s_axis_tvalid high -> output is held, s_axis_tready = 0, no beats are lost or duplicated, counters advance once per beat.
- Manual write vs auto step: cfg_shift_wr to ch2 with value 31 on the same cycle as ch2's 4th clip -> shift[2] = MAX_SHIFT (8), counters 0.
